// File: rtl/router_sync_n.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_n
// Purpose  : N-channel synchroniser between the router FSM/register block and
//            its output FIFOs. Latches the destination address on a header
//            strobe, steers the FIFO write enable and full status for that
//            address, derives valid-out from the FIFO empty flags, and runs a
//            read-aware per-channel timeout that soft-resets an unread FIFO.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_CH  - number of output channels/FIFOs (2..8)
//   ADDR_W  - width of the din address field (2**ADDR_W >= NUM_CH)
//   TIMEOUT - cycles a non-empty, unread channel waits before soft reset
//   CNT_W   - timeout counter width (TIMEOUT <= 2**CNT_W)
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   detect_add in   header strobe; latch din as destination address
//   din        in   destination address [ADDR_W-1:0]
//   we_reg     in   write request from router FSM
//   re         in   per-channel FIFO read enable [NUM_CH-1:0]
//   empty      in   per-channel FIFO empty [NUM_CH-1:0]
//   full       in   per-channel FIFO full [NUM_CH-1:0]
//   we         out  one-hot FIFO write enable (combinational)
//   fifo_full  out  full flag of the addressed FIFO (combinational)
//   vout       out  valid-out = ~empty (combinational)
//   soft_reset out  per-channel timeout soft reset (registered)
//   addr_err   out  one-cycle pulse: latched address was out of range
// Build option:
//   ROUTER_SYNC_SR_STICKY_EN - when defined, soft_reset stays high after a
//   timeout until the channel is read, drains empty, or rst is applied.
// ============================================================================
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] din,
    input  logic              we_reg,
    input  logic [NUM_CH-1:0] re,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] we,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vout,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    // One extra bit so NUM_CH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]  c_NUM_CH = (ADDR_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] c_TERM   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO   = '0;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_COUNT = 2'd1;
    localparam logic [1:0] c_S_FIRE  = 2'd2;

    logic [ADDR_W-1:0] r_addr_q;
    logic              r_addr_vld;
    logic              r_addr_err;
    logic              w_din_ok;
    logic [NUM_CH-1:0] w_we;
    logic              w_fifo_full;
    logic [NUM_CH-1:0] w_vout;

    assign w_din_ok = ({1'b0, din} < c_NUM_CH);

    // ------------------------------------------------------------------------
    // Destination address latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q   <= '0;
            r_addr_vld <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (detect_add) begin
            r_addr_q   <= din;
            r_addr_vld <= w_din_ok;
            r_addr_err <= ~w_din_ok;
        end else begin
            r_addr_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Write steering and full mux. Both use the already-latched address, so a
    // header strobe in the same cycle as a write only affects the next cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_we        = '0;
        w_fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_addr_vld && (r_addr_q == ADDR_W'(i))) begin
                w_we[i]     = we_reg;
                w_fifo_full = full[i];
            end
        end
    end

    assign w_vout    = ~empty;
    assign we        = w_we;
    assign fifo_full = w_fifo_full;
    assign vout      = w_vout;
    assign addr_err  = r_addr_err;

    // ------------------------------------------------------------------------
    // Per-channel timeout FSM. IDLE->COUNT loads 1 so that, with no reads,
    // soft_reset rises exactly TIMEOUT cycles after vout rises.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_sr;
            logic             w_sr_nxt;

            // State register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                    r_sr    <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_sr    <= w_sr_nxt;
                end
            end

            // Next-state logic: empty beats read beats terminal count.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    c_S_IDLE: begin
                        if (w_vout[gi]) begin
                            w_state_nxt = c_S_COUNT;
                            w_cnt_nxt   = c_ONE;
                        end else begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_ZERO;
                        end
                    end
                    c_S_COUNT: begin
                        if (!w_vout[gi]) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_ZERO;
                        end else if (re[gi]) begin
                            w_state_nxt = c_S_COUNT;
                            w_cnt_nxt   = c_ZERO;
                        end else if (r_cnt == c_TERM) begin
                            w_state_nxt = c_S_FIRE;
                            w_cnt_nxt   = c_ZERO;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_ONE;
                        end
                    end
                    c_S_FIRE: begin
`ifdef ROUTER_SYNC_SR_STICKY_EN
                        // Hold the soft reset until the channel is serviced.
                        if (!w_vout[gi]) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_ZERO;
                        end else if (re[gi]) begin
                            w_state_nxt = c_S_COUNT;
                            w_cnt_nxt   = c_ZERO;
                        end else begin
                            w_state_nxt = c_S_FIRE;
                            w_cnt_nxt   = c_ZERO;
                        end
`else
                        if (!w_vout[gi]) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_ZERO;
                        end else begin
                            w_state_nxt = c_S_COUNT;
                            w_cnt_nxt   = c_ONE;
                        end
`endif
                    end
                    default: begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = c_ZERO;
                    end
                endcase
            end

            // Output logic: soft_reset is registered alongside the FIRE state.
            always_comb begin
                w_sr_nxt = (w_state_nxt == c_S_FIRE);
            end

            assign soft_reset[gi] = r_sr;
        end
    endgenerate

endmodule
`default_nettype wire
